mem_seq: RTL

- Parametrised RAM access sequencer. Drives the existing ram_ctrl pin-bus handshake to the RAM model.
- Walks an address range: base, base+stride, … for count transfers.
- Read mode streams returned words out over a valid/ready port. Write mode stores an incrementing pattern.
- Sits on the motherboard between the controlling FSM and the RAM hardware model, replacing single-word hand-coded read loops.

---
 rtl/mem_seq.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_seq.sv
// mem_seq : parametrised RAM access sequencer.
//
// Walks the addresses base, base+stride, ... for `count` transfers. It uses
// the ram_ctrl pin-bus handshake: raise a request pin, wait for the matching
// done pin, then drop the request. Read jobs stream each returned word out on
// a valid/ready port. Write jobs store an incrementing pattern that starts at
// wr_seed.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start, mode              start a job (sampled in IDLE only); 0 = read, 1 = write
//   base_addr, stride        first address and address increment (latched at start)
//   count, wr_seed           number of transfers and first write word (latched)
//   abort                    terminate the running job (status 2)
//   busy, done, status       job in progress, one-cycle end pulse, result code
//                            (0 ok, 1 timeout, 2 abort, 3 verify mismatch)
//   ram_ctrl_from_hw/to_hw   RAM status pins / RAM request pins
//   addr, data_from_hw,      RAM address, read data and write data
//   data_to_hw
//   rd_valid, rd_ready,      read stream handshake, data word and transfer index
//   rd_data, rd_index
//
// Optional feature: define MEM_SEQ_VERIFY_EN to read back every written word at
// the same address. On a readback mismatch the job ends with status 3 and addr
// stays at the failing address.
module mem_seq #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int CW      = 16,
   parameter int TIMEOUT = 255,
   parameter int RD_PIN  = 0,
   parameter int WR_PIN  = 1,
   parameter int RD_DONE = 0,
   parameter int WR_DONE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          mode,
   input  logic [AW-1:0] base_addr,
   input  logic [AW-1:0] stride,
   input  logic [CW-1:0] count,
   input  logic [DW-1:0] wr_seed,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [1:0]    status,
   input  logic [31:0]   ram_ctrl_from_hw,
   output logic [31:0]   ram_ctrl_to_hw,
   output logic [AW-1:0] addr,
   input  logic [DW-1:0] data_from_hw,
   output logic [DW-1:0] data_to_hw,
   output logic          rd_valid,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic [CW-1:0] rd_index
);

`ifdef MEM_SEQ_VERIFY_EN
   localparam bit VERIFY_EN = 1'b1;
`else
   localparam bit VERIFY_EN = 1'b0;
`endif

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_TIMEOUT = 2'd1;
   localparam logic [1:0] ST_ABORT   = 2'd2;
   localparam logic [1:0] ST_VERIFY  = 2'd3;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, DONE} state_t;

   state_t        state_q, state_d;
   logic          mode_q, mode_d;
   logic          verify_q, verify_d;
   logic [AW-1:0] stride_q, stride_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [31:0]   ctrl_q, ctrl_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [1:0]    status_q, status_d;
   logic          rd_valid_q, rd_valid_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic [CW-1:0] rd_index_q, rd_index_d;

   // A verify readback travels the read pins even inside a write job.
   logic use_wr, hw_done, last, tmo_expired, mismatch;
   assign use_wr      = mode_q & ~verify_q;
   assign hw_done     = use_wr ? ram_ctrl_from_hw[WR_DONE] : ram_ctrl_from_hw[RD_DONE];
   assign last        = (idx_q + CW'(1)) == count_q;
   assign tmo_expired = tmo_q == TW'(TIMEOUT - 1);
   assign mismatch    = data_from_hw != wdata_q;

   // Only the two done bits are meaningful; the remaining status pins are ignored.
   logic unused_from_hw;
   assign unused_from_hw = ^ram_ctrl_from_hw;

   // State and datapath registers; reset also drops the request pins at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         verify_q   <= 1'b0;
         stride_q   <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         tmo_q      <= '0;
         ctrl_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         status_q   <= ST_OK;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_index_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         verify_q   <= verify_d;
         stride_q   <= stride_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         tmo_q      <= tmo_d;
         ctrl_q     <= ctrl_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         status_q   <= status_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_index_q <= rd_index_d;
      end
   end

   // Next-state logic. Abort outranks a RAM completion or a stream handshake
   // that arrives in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = (count == '0) ? DONE : ISSUE;
         ISSUE: begin
            if (abort)         state_d = DONE;
            else if (!hw_done) state_d = WAIT;
         end
         WAIT: begin
            if (abort) state_d = DONE;
            else if (hw_done) begin
               if (!mode_q)        state_d = PUSH;
               else if (verify_q)  state_d = (mismatch || last) ? DONE : ISSUE;
               else if (VERIFY_EN) state_d = ISSUE;
               else                state_d = last ? DONE : ISSUE;
            end else if (tmo_expired) state_d = DONE;
         end
         PUSH: begin
            if (abort)         state_d = DONE;
            else if (rd_ready) state_d = last ? DONE : ISSUE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values for the registered outputs and the job context.
   always_comb begin
      mode_d     = mode_q;
      verify_d   = verify_q;
      stride_d   = stride_q;
      addr_d     = addr_q;
      count_d    = count_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      tmo_d      = tmo_q;
      ctrl_d     = ctrl_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      status_d   = status_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      rd_index_d = rd_index_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               mode_d   = mode;
               verify_d = 1'b0;
               stride_d = stride;
               count_d  = count;
               idx_d    = '0;
               addr_d   = base_addr;
               wdata_d  = wr_seed;
               busy_d   = 1'b1;
               status_d = ST_OK;
            end
         end
         ISSUE: begin
            tmo_d = '0;
            if (abort) status_d = ST_ABORT;
            else if (!hw_done) begin
               ctrl_d = '0;
               if (use_wr) ctrl_d[WR_PIN] = 1'b1;
               else        ctrl_d[RD_PIN] = 1'b1;
            end
         end
         WAIT: begin
            if (abort) begin
               ctrl_d   = '0;
               status_d = ST_ABORT;
            end else if (hw_done) begin
               ctrl_d = '0;
               if (!mode_q) begin
                  rd_data_d  = data_from_hw;
                  rd_index_d = idx_q;
                  rd_valid_d = 1'b1;
               end else if (verify_q && mismatch) begin
                  status_d = ST_VERIFY;
               end else if (!verify_q && VERIFY_EN) begin
                  verify_d = 1'b1;
               end else begin
                  verify_d = 1'b0;
                  if (!last) begin
                     idx_d   = idx_q + CW'(1);
                     addr_d  = addr_q + stride_q;
                     wdata_d = wdata_q + DW'(1);
                  end
               end
            end else if (tmo_expired) begin
               ctrl_d   = '0;
               status_d = ST_TIMEOUT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         PUSH: begin
            if (abort) begin
               rd_valid_d = 1'b0;
               status_d   = ST_ABORT;
            end else if (rd_ready) begin
               rd_valid_d = 1'b0;
               if (!last) begin
                  idx_d   = idx_q + CW'(1);
                  addr_d  = addr_q + stride_q;
                  wdata_d = wdata_q + DW'(1);
               end
            end
         end
         DONE: begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            ctrl_d     = '0;
            rd_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign status         = status_q;
   assign ram_ctrl_to_hw = ctrl_q;
   assign addr           = addr_q;
   assign data_to_hw     = wdata_q;
   assign rd_valid       = rd_valid_q;
   assign rd_data        = rd_data_q;
   assign rd_index       = rd_index_q;

endmodule
